// File: rtl/des_subkey_gen.sv
// DES key-schedule engine: loads a 64-bit key through PC-1 and then hands out
// the sixteen 48-bit round subkeys one per valid/ready transfer, either in
// encrypt order (K1..K16, left rotations) or decrypt order (K16..K1, right
// rotations). Bit 1 is the MSB of every vector, matching the DES tables.

// PC-2 compression: selects 48 of the 56 C/D bits to form a round subkey.
module des_pc2 (
    input  logic [1:56] cd,
    output logic [1:48] k
);

    localparam int PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Pure wiring: each subkey bit picks one C/D bit from the table.
    always_comb begin
        k = '0;
        for (int i = 1; i <= 48; i++) begin
            k[i] = cd[PC2_TBL[i]];
        end
    end

endmodule

module des_subkey_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] key,
    output logic        busy,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [1:48] subkey,
    output logic [4:0]  sk_index,
    output logic        sk_last
);

    // PC-1 drops the eight parity bits and splits the key into C0 (1..28)
    // and D0 (29..56).
    localparam int PC1_TBL [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state, state_nxt;
    logic [1:28] c_reg, c_nxt;
    logic [1:28] d_reg, d_nxt;
    // Five bits so that round 16 is representable alongside the idle value 0.
    logic [4:0]  idx, idx_nxt;
    logic [4:0]  idx_inc;
    logic        mode, mode_nxt;
    logic [1:56] cd0;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] p;
        p = '0;
        for (int i = 1; i <= 56; i++) begin
            p[i] = k[PC1_TBL[i]];
        end
        return p;
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
    function automatic logic single_shift(input logic [4:0] n);
        return (n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16);
    endfunction

    function automatic logic [1:28] rotl(input logic [1:28] x, input logic one);
        return one ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
    endfunction

    function automatic logic [1:28] rotr(input logic [1:28] x, input logic one);
        return one ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
    endfunction

    // State and key-register update; reset clears everything so the subkey
    // output reads as all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            c_reg <= '0;
            d_reg <= '0;
            idx   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            c_reg <= c_nxt;
            d_reg <= d_nxt;
            idx   <= idx_nxt;
            mode  <= mode_nxt;
        end
    end

    // Next-state and outputs: load on start, step the rotation on each
    // transfer, return to IDLE after the final subkey is taken.
    always_comb begin
        state_nxt = state;
        c_nxt     = c_reg;
        d_nxt     = d_reg;
        idx_nxt   = idx;
        mode_nxt  = mode;
        cd0       = pc1(key);
        idx_inc   = idx + 5'd1;
        busy      = (state == RUN);
        sk_valid  = (state == RUN);
        sk_index  = idx;
        sk_last   = (state == RUN) &&
                    ((!mode && (idx == 5'd16)) || (mode && (idx == 5'd1)));

        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt  = decrypt;
                    state_nxt = RUN;
                    if (decrypt) begin
                        // Total rotation over 16 rounds is 28, so C16 = C0.
                        c_nxt   = cd0[1:28];
                        d_nxt   = cd0[29:56];
                        idx_nxt = 5'd16;
                    end else begin
                        c_nxt   = rotl(cd0[1:28], 1'b1);
                        d_nxt   = rotl(cd0[29:56], 1'b1);
                        idx_nxt = 5'd1;
                    end
                end
            end
            RUN: begin
                if (sk_ready) begin
                    if (sk_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = 5'd0;
                    end else if (!mode) begin
                        c_nxt   = rotl(c_reg, single_shift(idx_inc));
                        d_nxt   = rotl(d_reg, single_shift(idx_inc));
                        idx_nxt = idx_inc;
                    end else begin
                        c_nxt   = rotr(c_reg, single_shift(idx));
                        d_nxt   = rotr(d_reg, single_shift(idx));
                        idx_nxt = idx - 5'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    des_pc2 u_pc2 (
        .cd ({c_reg, d_reg}),
        .k  (subkey)
    );

endmodule
